// File: rtl/tdm_demux_4ch.sv
// Receive side of the 4:1 TDM channel mux: steers slots 0..3 into per-channel
// holding registers, tracks frame alignment and counts alignment violations.
//
// state  | meaning
// HUNT   | waiting for a beat carrying sof; non-sof beats are discarded
// LOCKED | aligned; slot holds the next expected slot index
module tdm_demux_4ch #(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic [W-1:0]    ch0_data,
  output logic [W-1:0]    ch1_data,
  output logic [W-1:0]    ch2_data,
  output logic [W-1:0]    ch3_data,
  output logic [3:0]      ch_valid,
  output logic            frame_done,
  output logic            sync_err,
  output logic            locked,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] slot, slot_nxt;
  logic [3:0] wr_en;
  logic       err_nxt;
  logic       done_nxt;

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_en     = 4'b0000;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            wr_en[0]  = 1'b1;
            slot_nxt  = 2'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof) begin
            // An early sof abandons the partial frame and restarts at slot 0.
            wr_en[0] = 1'b1;
            slot_nxt = 2'd1;
            err_nxt  = (slot != 2'd0);
          end else if (slot == 2'd0) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end else begin
            wr_en[slot] = 1'b1;
            slot_nxt    = slot + 2'd1;
            // Reaching slot 3 implies slots 0..2 of this frame had no error.
            done_nxt    = (slot == 2'd3);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      ch0_data   <= '0;
      ch1_data   <= '0;
      ch2_data   <= '0;
      ch3_data   <= '0;
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      ch_valid   <= wr_en;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      locked     <= (state_nxt == LOCKED);
      if (wr_en[0]) ch0_data <= in_data;
      if (wr_en[1]) ch1_data <= in_data;
      if (wr_en[2]) ch2_data <= in_data;
      if (wr_en[3]) ch3_data <= in_data;
      if (err_nxt && (err_cnt != {ERRW{1'b1}})) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
